// File: rtl/coef_ram_arbiter_if.sv
// coef_ram_arbiter_if: host-write, FIR-read and RAM port bundle for coef_ram_arbiter
interface coef_ram_arbiter_if #(
   parameter int FILTER_BITS = 2,
   parameter int TAP_BITS    = 8
);
   localparam int ADDR_W = FILTER_BITS + TAP_BITS;
   logic              coef_wr_stb;
   logic [7:0]        coef_wr_lsb;
   logic [7:0]        coef_wr_msb;
   logic [7:0]        filter_select;
   logic [7:0]        taps_per_filter;
   logic              coef_addr_rst;
   logic              fir_busy;
   logic              fir_rd_req;
   logic [ADDR_W-1:0] fir_rd_addr;
   logic              fir_rd_gnt;
   logic              fir_rd_valid;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_wdata;
   logic              wr_pending;
   logic              wr_overflow;
   logic              load_done;
   modport slave (
      input  coef_wr_stb, coef_wr_lsb, coef_wr_msb, filter_select, taps_per_filter,
             coef_addr_rst, fir_busy, fir_rd_req, fir_rd_addr,
      output fir_rd_gnt, fir_rd_valid, ram_en, ram_we, ram_addr, ram_wdata,
             wr_pending, wr_overflow, load_done
   );
   modport master (
      output coef_wr_stb, coef_wr_lsb, coef_wr_msb, filter_select, taps_per_filter,
             coef_addr_rst, fir_busy, fir_rd_req, fir_rd_addr,
      input  fir_rd_gnt, fir_rd_valid, ram_en, ram_we, ram_addr, ram_wdata,
             wr_pending, wr_overflow, load_done
   );
endinterface

// File: rtl/coef_ram_arbiter.sv
// coef_ram_arbiter: single-port FIR coefficient RAM shared by queued host writes and priority FIR reads.
// Defining COEF_STARVE_GUARD_EN forces one queued write through after STARVE_LIMIT waiting cycles.
module coef_ram_arbiter #(
   parameter int FILTER_BITS  = 2,
   parameter int TAP_BITS     = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 64
) (
   input logic                clk,
   input logic                reset_n,
   coef_ram_arbiter_if.slave  bus
);
   localparam int ADDR_W = FILTER_BITS + TAP_BITS;
   localparam int PW     = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, FIR_RD, HOST_WR} state_t;
   state_t                 r_state, w_next;
   logic [ADDR_W+15:0]     r_q [FIFO_DEPTH];
   logic [PW-1:0]          r_wp, r_rp;
   logic [PW:0]            r_cnt;
   logic [FILTER_BITS-1:0] r_fsel, w_fidx;
   logic [TAP_BITS-1:0]    r_tap, w_ptr, w_last;
   logic [ADDR_W-1:0]      r_addr, w_addr;
   logic [15:0]            r_wdata, w_wdata;
   logic                   r_gnt, r_valid, r_en, r_we, r_ovf, r_ld;
   logic                   w_full, w_push, w_pop, w_force, w_unused;
   assign w_fidx   = bus.filter_select[FILTER_BITS-1:0];
   assign w_ptr    = (bus.coef_addr_rst || w_fidx != r_fsel) ? '0 : r_tap;
   assign w_last   = TAP_BITS'(bus.taps_per_filter - 8'd1);
   assign w_full   = r_cnt == (PW+1)'(FIFO_DEPTH);
   assign w_push   = bus.coef_wr_stb && !w_full;
   assign w_pop    = w_next == HOST_WR;
   assign w_unused = ^{bus.filter_select, STARVE_LIMIT[0]};
`ifdef COEF_STARVE_GUARD_EN
   localparam int WW = $clog2(STARVE_LIMIT + 1);
   logic [WW-1:0] r_wait;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_wait <= '0;
      else
         r_wait <= (r_cnt != '0 && r_state != HOST_WR) ? r_wait + WW'(r_wait != WW'(STARVE_LIMIT)) : '0;
   end
   assign w_force = r_wait == WW'(STARVE_LIMIT) && r_state != HOST_WR && r_cnt != '0;
`else
   assign w_force = 1'b0;
`endif
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_en    <= 1'b0;
         r_we    <= 1'b0;
         r_gnt   <= 1'b0;
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next;
         r_en    <= w_next != IDLE;
         r_we    <= w_next == HOST_WR;
         r_gnt   <= w_next == FIR_RD;
         r_valid <= r_gnt;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
      end
   end
   // a read just served returns to IDLE before any queued write is considered
   always_comb begin
      w_next = w_force ? HOST_WR :
               bus.fir_rd_req ? FIR_RD :
               (r_state != FIR_RD && r_cnt != '0 && !bus.fir_busy) ? HOST_WR : IDLE;
   end
   always_comb begin
      w_addr  = (w_next == HOST_WR) ? r_q[r_rp][ADDR_W+15:16] : (w_next == FIR_RD) ? bus.fir_rd_addr : '0;
      w_wdata = (w_next == HOST_WR) ? r_q[r_rp][15:0] : '0;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_tap  <= '0;
         r_fsel <= '0;
         r_ovf  <= 1'b0;
         r_ld   <= 1'b0;
      end else begin
         r_wp   <= r_wp + PW'(w_push);
         r_rp   <= r_rp + PW'(w_pop);
         r_cnt  <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
         r_tap  <= !w_push ? w_ptr : (w_ptr == w_last) ? '0 : w_ptr + TAP_BITS'(1);
         r_fsel <= w_fidx;
         r_ovf  <= (bus.coef_wr_stb && w_full) || (r_ovf && !bus.coef_addr_rst);
         r_ld   <= w_push && w_ptr == w_last;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) r_q[r_wp] <= {w_fidx, w_ptr, bus.coef_wr_msb, bus.coef_wr_lsb};
   end
   assign bus.fir_rd_gnt   = r_gnt;
   assign bus.fir_rd_valid = r_valid;
   assign bus.ram_en       = r_en;
   assign bus.ram_we       = r_we;
   assign bus.ram_addr     = r_addr;
   assign bus.ram_wdata    = r_wdata;
   assign bus.wr_pending   = r_cnt != '0;
   assign bus.wr_overflow  = r_ovf;
   assign bus.load_done    = r_ld;
endmodule
